// File: rtl/seg_display_arbiter_pkg.sv
// seg_pkg: shared constants, frame snapshot type and digit extraction for the seg display arbiter
//   NUM_DIGITS/SEG_W : digits per frame and segments per digit
//   SEG_BLANK        : all-segments-off pattern
//   frame_t          : one client's latched frame (segments, dp, blink mask)
//   digit_of         : segment pattern of digit k from a 56-bit frame bus
package seg_pkg;
   localparam int NUM_DIGITS = 8;
   localparam int SEG_W = 7;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0;
   typedef struct packed {
      logic [NUM_DIGITS*SEG_W-1:0] seg;
      logic [NUM_DIGITS-1:0] dp;
      logic [NUM_DIGITS-1:0] blink;
   } frame_t;
   function automatic logic [SEG_W-1:0] digit_of(input logic [NUM_DIGITS*SEG_W-1:0] bus, input logic [2:0] k);
      return bus[k*SEG_W +: SEG_W];
   endfunction
endpackage

// File: rtl/seg_display_arbiter_tick_gen.sv
// tick_gen: free-running modulo-DIV counter with a one-cycle tick on its last count
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear, wins over the wrap
//   tick       : high while the count equals DIV-1
module tick_gen #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);
   localparam int W = $clog2(DIV);
   logic [W-1:0] cnt;
   if (DIV < 2) begin : g_div_check
      $error("tick_gen: DIV must be at least 2");
   end
   assign tick = cnt == W'(DIV - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: frame-boundary fixed-priority sharing of two 4-digit seven-segment banks
//   IN_CLK, IN_RST_N            : clock, asynchronous active-low reset
//   IN_REQ                      : level request per client, index 0 highest priority
//   IN_SEG, IN_DP, IN_BLINK     : per-client 8-digit segments, decimal points, blink mask
//   OUT_GRANT                   : one-hot owner of the current frame, zero when idle
//   OUT_FRAME                   : one-cycle pulse on each frame boundary
//   OUT_SEG0*/OUT_SEG1*         : left bank (digits 4..7) / right bank (digits 0..3) drive
module seg_display_arbiter
   import seg_pkg::*;
#(
   parameter int CLK_HZ = 100_000_000,
   parameter int SCAN_HZ = 1000,
   parameter int BLINK_HZ = 2,
   parameter int NUM_REQ = 4
) (
   input  logic                              IN_CLK,
   input  logic                              IN_RST_N,
   input  logic [NUM_REQ-1:0]                IN_REQ,
   input  logic [NUM_REQ*NUM_DIGITS*SEG_W-1:0] IN_SEG,
   input  logic [NUM_REQ*NUM_DIGITS-1:0]     IN_DP,
   input  logic [NUM_REQ*NUM_DIGITS-1:0]     IN_BLINK,
   output logic [NUM_REQ-1:0]                OUT_GRANT,
   output logic                              OUT_FRAME,
   output logic [SEG_W-1:0]                  OUT_SEG0DATA,
   output logic [SEG_W-1:0]                  OUT_SEG1DATA,
   output logic [3:0]                        OUT_SEG0SELE,
   output logic [3:0]                        OUT_SEG1SELE,
   output logic                              OUT_SEG0DP,
   output logic                              OUT_SEG1DP
);
   localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
   localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
   logic scan_tick, blink_tick, boundary, grant_change, phase, phase_nxt, dark0, dark1;
   logic [1:0] idx, idx_nxt;
   logic [NUM_REQ-1:0] grant_nxt;
   frame_t snap, snap_nxt, cand;
   tick_gen #(.DIV(SCAN_DIV)) u_scan (
      .clk(IN_CLK), .rst_n(IN_RST_N), .clr(1'b0), .tick(scan_tick)
   );
   tick_gen #(.DIV(BLINK_DIV)) u_blink (
      .clk(IN_CLK), .rst_n(IN_RST_N), .clr(grant_change), .tick(blink_tick)
   );
   // Walk from lowest priority upward so the highest-priority requester is written last.
   always_comb begin
      grant_nxt = '0;
      cand = '0;
      for (int r = NUM_REQ - 1; r >= 0; r--)
         if (IN_REQ[r]) begin
            grant_nxt = '0;
            grant_nxt[r] = 1'b1;
            cand = {IN_SEG[r*NUM_DIGITS*SEG_W +: NUM_DIGITS*SEG_W], IN_DP[r*NUM_DIGITS +: NUM_DIGITS],
                    IN_BLINK[r*NUM_DIGITS +: NUM_DIGITS]};
         end
   end
   assign idx_nxt = idx + 2'd1;
   assign boundary = scan_tick && idx == 2'd3;
   assign grant_change = boundary && grant_nxt != OUT_GRANT;
   assign snap_nxt = boundary ? cand : snap;
   // A new owner always starts visible, even if the blink counter wraps on the same edge.
   assign phase_nxt = grant_change ? 1'b0 : phase ^ blink_tick;
   // Outputs are computed from the post-edge snapshot so a new owner's digit 0/4 shows on the boundary edge.
   assign dark1 = phase_nxt && snap_nxt.blink[{1'b0, idx_nxt}];
   assign dark0 = phase_nxt && snap_nxt.blink[{1'b1, idx_nxt}];
   always_ff @(posedge IN_CLK or negedge IN_RST_N)
      if (!IN_RST_N) begin
         idx <= 2'd3;
         phase <= 1'b0;
         snap <= '0;
         OUT_GRANT <= '0;
         OUT_FRAME <= 1'b0;
         OUT_SEG0DATA <= SEG_BLANK;
         OUT_SEG1DATA <= SEG_BLANK;
         OUT_SEG0SELE <= '0;
         OUT_SEG1SELE <= '0;
         OUT_SEG0DP <= 1'b0;
         OUT_SEG1DP <= 1'b0;
      end else begin
         phase <= phase_nxt;
         OUT_FRAME <= boundary;
         if (boundary) OUT_GRANT <= grant_nxt;
         if (scan_tick) begin
            idx <= idx_nxt;
            snap <= snap_nxt;
            OUT_SEG1SELE <= 4'b1 << idx_nxt;
            OUT_SEG0SELE <= 4'b1 << idx_nxt;
            OUT_SEG1DATA <= dark1 ? SEG_BLANK : digit_of(snap_nxt.seg, {1'b0, idx_nxt});
            OUT_SEG0DATA <= dark0 ? SEG_BLANK : digit_of(snap_nxt.seg, {1'b1, idx_nxt});
            OUT_SEG1DP <= snap_nxt.dp[{1'b0, idx_nxt}] && !dark1;
            OUT_SEG0DP <= snap_nxt.dp[{1'b1, idx_nxt}] && !dark0;
         end
      end
endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter: randomized and directed checks of seg_display_arbiter against an edge-count model
module tb_seg_display_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [3:0] req = '0;
   logic [223:0] seg = '0;
   logic [31:0] dp = '0;
   logic [31:0] bl = '0;
   logic [3:0] grant, sel0, sel1;
   logic frame, dp0, dp1;
   logic [6:0] s0, s1;
   int errors = 0;
   int checks = 0;
   int n, bl_n, m_ix;
   logic [3:0] m_grant, ng, e_sel;
   logic [55:0] m_seg;
   logic [7:0] m_dp, m_bl;
   logic e_frame, e_dp0, e_dp1, dark0, dark1;
   logic [6:0] e_s0, e_s1;

   always #5 clk = ~clk;

   seg_display_arbiter #(.CLK_HZ(1000), .SCAN_HZ(100), .BLINK_HZ(5), .NUM_REQ(4)) dut (
      .IN_CLK(clk), .IN_RST_N(rst_n), .IN_REQ(req), .IN_SEG(seg), .IN_DP(dp), .IN_BLINK(bl),
      .OUT_GRANT(grant), .OUT_FRAME(frame), .OUT_SEG0DATA(s0), .OUT_SEG1DATA(s1),
      .OUT_SEG0SELE(sel0), .OUT_SEG1SELE(sel1), .OUT_SEG0DP(dp0), .OUT_SEG1DP(dp1)
   );

   function automatic logic [28:0] act();
      return {grant, frame, s1, s0, sel1, sel0, dp1, dp0};
   endfunction

   function automatic logic [28:0] expv();
      return {m_grant, e_frame, e_s1, e_s0, e_sel, e_sel, e_dp1, e_dp0};
   endfunction

   task automatic model_clear();
      n = 0; bl_n = 0; m_ix = 3;
      m_grant = '0; m_seg = '0; m_dp = '0; m_bl = '0;
      e_frame = 1'b0; e_s0 = '0; e_s1 = '0; e_sel = '0; e_dp0 = 1'b0; e_dp1 = 1'b0;
   endtask

   // One clock: the model reads the inputs present at the rising edge, then both are sampled on the falling edge.
   // Slot m (counted from reset release) ends on edge 10*m; the shown index is (3+m) mod 4; index 0 opens a frame.
   // Blink phase is the parity of whole 100-edge periods since reset or the last owner change.
   task automatic cyc();
      @(posedge clk);
      n++;
      bl_n++;
      e_frame = 1'b0;
      if (n % 10 == 0) begin
         m_ix = (3 + n / 10) % 4;
         if (m_ix == 0) begin
            ng = '0;
            for (int r = 0; r < 4; r++) if (req[r] && ng == 0) ng[r] = 1'b1;
            if (ng != m_grant) bl_n = 0;
            m_grant = ng;
            m_seg = '0; m_dp = '0; m_bl = '0;
            for (int r = 0; r < 4; r++)
               if (ng[r]) begin
                  m_seg = seg[r*56 +: 56];
                  m_dp = dp[r*8 +: 8];
                  m_bl = bl[r*8 +: 8];
               end
            e_frame = 1'b1;
         end
         dark1 = ((bl_n / 100) % 2 == 1) && m_bl[m_ix];
         dark0 = ((bl_n / 100) % 2 == 1) && m_bl[m_ix + 4];
         e_sel = 4'b1 << m_ix;
         e_s1 = dark1 ? 7'd0 : m_seg[m_ix*7 +: 7];
         e_s0 = dark0 ? 7'd0 : m_seg[(m_ix + 4)*7 +: 7];
         e_dp1 = m_dp[m_ix] && !dark1;
         e_dp0 = m_dp[m_ix + 4] && !dark0;
      end
      @(negedge clk);
   endtask

   task automatic set_client(input int r, input logic [55:0] sv, input logic [7:0] dv, input logic [7:0] bv);
      seg[r*56 +: 56] = sv;
      dp[r*8 +: 8] = dv;
      bl[r*8 +: 8] = bv;
   endtask

   task automatic test_reset();
      model_clear();
      repeat (3) @(negedge clk);
      checks++;
      if (act() !== 29'd0) begin errors++; $display("FAIL reset_outputs: dut=%h want=0", act()); end
      rst_n = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         cyc();
         checks++;
         if (act() !== expv()) begin errors++; $display("FAIL reset_scan c=%0d: dut=%h model=%h", c, act(), expv()); end
      end
      checks++;
      if ({frame, sel0, sel1, s0, s1, grant} !== {1'b1, 4'b0001, 4'b0001, 7'd0, 7'd0, 4'd0}) begin
         errors++;
         $display("FAIL reset_first_frame: frame=%b sel0=%b sel1=%b s0=%h s1=%h grant=%b", frame, sel0, sel1, s0, s1, grant);
      end
   endtask

   task automatic test_single_client();
      logic [55:0] sv;
      bit hit = 0;
      for (int k = 0; k < 8; k++) sv[k*7 +: 7] = 7'(k + 1);
      set_client(0, sv, 8'h00, 8'h00);
      req = 4'b0001;
      for (int c = 0; c < 60 && !hit; c++) begin
         cyc();
         checks++;
         if (act() !== expv()) begin errors++; $display("FAIL single_wait: dut=%h model=%h", act(), expv()); end
         hit = e_frame;
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL single_timeout: no boundary within 60 cycles"); end
      for (int k = 0; k < 4; k++) begin
         if (k > 0)
            repeat (10) begin
               cyc();
               checks++;
               if (act() !== expv()) begin errors++; $display("FAIL single_scan: dut=%h model=%h", act(), expv()); end
            end
         checks++;
         if ({grant, s1, s0, sel1, sel0} !== {4'b0001, 7'(k + 1), 7'(k + 5), 4'b1 << k, 4'b1 << k}) begin
            errors++;
            $display("FAIL single_digit k=%0d: grant=%b s1=%h s0=%h sel1=%b sel0=%b", k, grant, s1, s0, sel1, sel0);
         end
      end
   endtask

   task automatic test_preempt();
      bit hit = 0;
      set_client(2, {$urandom, $urandom} | 56'h1, 8'($urandom), 8'h00);
      req = 4'b0100;
      for (int c = 0; c < 60 && !hit; c++) begin
         cyc();
         checks++;
         if (act() !== expv()) begin errors++; $display("FAIL preempt_wait: dut=%h model=%h", act(), expv()); end
         hit = e_frame;
      end
      checks++;
      if (grant !== 4'b0100) begin errors++; $display("FAIL preempt_owner: grant=%b want=0100", grant); end
      repeat (13) begin
         cyc();
         checks++;
         if (act() !== expv()) begin errors++; $display("FAIL preempt_frame: dut=%h model=%h", act(), expv()); end
      end
      req = 4'b0101;
      hit = 0;
      for (int c = 0; c < 40 && !hit; c++) begin
         cyc();
         hit = e_frame;
         checks++;
         if (act() !== expv() || grant !== (hit ? 4'b0001 : 4'b0100)) begin
            errors++;
            $display("FAIL preempt_hold: dut=%h model=%h grant=%b", act(), expv(), grant);
         end
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL preempt_timeout: no boundary within 40 cycles"); end
   endtask

   task automatic test_blink();
      int dark_d0 = 0, dark_d1 = 0;
      set_client(1, {$urandom, $urandom} | {8{7'h01}}, 8'h01, 8'h01);
      req = 4'b0010;
      for (int c = 0; c < 500; c++) begin
         cyc();
         checks++;
         if (act() !== expv()) begin errors++; $display("FAIL blink_scan: dut=%h model=%h", act(), expv()); end
         if (grant == 4'b0010 && sel1 == 4'b0001 && s1 == 7'd0 && !dp1) dark_d0++;
         if (grant == 4'b0010 && sel1 == 4'b0010 && s1 == 7'd0) dark_d1++;
      end
      checks++;
      if (dark_d0 == 0) begin errors++; $display("FAIL blink_dark: digit0 dark cycles=%0d want>0", dark_d0); end
      checks++;
      if (dark_d1 != 0) begin errors++; $display("FAIL blink_steady: digit1 dark cycles=%0d want 0", dark_d1); end
   endtask

   task automatic test_drop();
      bit hit = 0;
      set_client(3, {$urandom, $urandom} | {8{7'h40}}, 8'hFF, 8'h00);
      req = 4'b1000;
      for (int c = 0; c < 60 && !hit; c++) begin
         cyc();
         checks++;
         if (act() !== expv()) begin errors++; $display("FAIL drop_wait: dut=%h model=%h", act(), expv()); end
         hit = e_frame;
      end
      repeat (23) begin
         cyc();
         checks++;
         if (act() !== expv()) begin errors++; $display("FAIL drop_frame: dut=%h model=%h", act(), expv()); end
      end
      req = 4'b0000;
      hit = 0;
      for (int c = 0; c < 40 && !hit; c++) begin
         cyc();
         hit = e_frame;
         checks++;
         if (act() !== expv() || (!hit && (grant !== 4'b1000 || s1 == 7'd0))) begin
            errors++;
            $display("FAIL drop_keep: dut=%h model=%h", act(), expv());
         end
      end
      checks++;
      if ({grant, s0, s1, dp0, dp1, sel0} !== {4'd0, 7'd0, 7'd0, 2'b00, 4'b0001}) begin
         errors++;
         $display("FAIL drop_idle: grant=%b s0=%h s1=%h dp=%b%b sel0=%b", grant, s0, s1, dp0, dp1, sel0);
      end
      repeat (10) cyc();
      checks++;
      if ({sel1, s1} !== {4'b0010, 7'd0}) begin errors++; $display("FAIL drop_scan: sel1=%b s1=%h want 0010/00", sel1, s1); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 5) == 0)
            set_client(int'($urandom_range(0, 3)), {$urandom, $urandom}, 8'($urandom), 8'($urandom));
         cyc();
         checks++;
         if (act() !== expv()) begin errors++; $display("FAIL random c=%0d: dut=%h model=%h", c, act(), expv()); end
      end
   endtask

   task automatic test_mid_reset();
      bit hit = 0;
      int gap = 0;
      set_client(0, {$urandom, $urandom} | 56'h1, 8'hFF, 8'h00);
      req = 4'b0001;
      for (int c = 0; c < 60 && !hit; c++) begin
         cyc();
         checks++;
         if (act() !== expv()) begin errors++; $display("FAIL midrst_wait: dut=%h model=%h", act(), expv()); end
         hit = e_frame;
      end
      repeat (23) cyc();
      #2 rst_n = 1'b0;
      model_clear();
      #1;
      checks++;
      if (act() !== 29'd0) begin errors++; $display("FAIL midrst_async: dut=%h want=0", act()); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 1; c <= 30 && gap == 0; c++) begin
         cyc();
         checks++;
         if (act() !== expv()) begin errors++; $display("FAIL midrst_scan: dut=%h model=%h", act(), expv()); end
         if (frame === 1'b1) gap = c;
      end
      checks++;
      if (gap != 10) begin errors++; $display("FAIL midrst_frame_gap: got=%0d want=10", gap); end
   endtask

   initial begin
      test_reset();
      test_single_client();
      test_preempt();
      test_blink();
      test_drop();
      test_random();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
